// File: rtl/ctrl_defs.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, funct
// codes and ALU operation selects.
package ctrl_defs;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BEQ      = 4'd8,
      S_ADDI_EX  = 4'd9,
      S_ADDI_WB  = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam int NUM_STATES = 12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_NOR = 6'b100111;

   localparam logic [3:0] SEL_AND = 4'd0;
   localparam logic [3:0] SEL_OR  = 4'd1;
   localparam logic [3:0] SEL_ADD = 4'd2;
   localparam logic [3:0] SEL_SUB = 4'd6;
   localparam logic [3:0] SEL_SLT = 4'd7;
   localparam logic [3:0] SEL_NOR = 4'd12;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   function automatic logic opcode_known(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational Funct-to-ALU-operation mapping for R-type instructions.
// Unknown Funct values fall back to ADD and raise Bad.
module alu_decoder
   import ctrl_defs::*;
(
   input  logic [5:0] Funct,
   output logic [3:0] Sel,
   output logic       Bad
);

   always_comb begin
      Sel = SEL_ADD;
      Bad = 1'b0;
      case (Funct)
         FN_AND:  Sel = SEL_AND;
         FN_OR:   Sel = SEL_OR;
         FN_ADD:  Sel = SEL_ADD;
         FN_SUB:  Sel = SEL_SUB;
         FN_SLT:  Sel = SEL_SLT;
         FN_NOR:  Sel = SEL_NOR;
         default: Bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/unidad_control.sv
// Multicycle Moore control FSM: decodes datapath strobes from the state
// register and counts completed instruction fetches.
module unidad_control
   import ctrl_defs::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         Opcode,
   input  logic [5:0]         Funct,
   input  logic               ZF,
   output logic               PCEn,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [3:0]         Sel,
   output logic               Illegal,
   output logic [STATE_W-1:0] Estado,
   output logic [31:0]        InstrCount
);

   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] state_next;
   logic [31:0]        instr_count_reg;
   state_t             cur;
   logic               cur_valid;
   logic [3:0]         rtype_sel;
   logic               rtype_bad;

   alu_decoder u_alu_decoder (
      .Funct (Funct),
      .Sel   (rtype_sel),
      .Bad   (rtype_bad)
   );

   // Encodings past the last state are treated as unreachable and recover to FETCH.
   assign cur       = state_t'(state_reg[3:0]);
   assign cur_valid = (state_reg < STATE_W'(NUM_STATES));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= STATE_W'(S_FETCH);
         instr_count_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         if (cur_valid && cur == S_FETCH)
            instr_count_reg <= instr_count_reg + 32'd1;
      end
   end

   always_comb begin
      state_next = STATE_W'(S_FETCH);
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      PCSrc      = PC_ALU;
      Sel        = SEL_AND;
      Illegal    = 1'b0;
      if (cur_valid) begin
         case (cur)
            S_FETCH: begin
               MemRead    = 1'b1;
               IRWrite    = 1'b1;
               ALUSrcB    = SRCB_FOUR;
               Sel        = SEL_ADD;
               PCEn       = 1'b1;
               state_next = STATE_W'(S_DECODE);
            end
            S_DECODE: begin
               ALUSrcB = SRCB_BR;
               Sel     = SEL_ADD;
               case (Opcode)
                  OP_RTYPE:      state_next = STATE_W'(S_RTYPE_EX);
                  OP_LW, OP_SW:  state_next = STATE_W'(S_MEMADR);
                  OP_BEQ:        state_next = STATE_W'(S_BEQ);
                  OP_ADDI:       state_next = STATE_W'(S_ADDI_EX);
                  OP_J:          state_next = STATE_W'(S_JUMP);
                  default:       Illegal    = 1'b1;
               endcase
            end
            S_MEMADR: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = SRCB_IMM;
               Sel        = SEL_ADD;
               state_next = (Opcode == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
            end
            S_MEMRD: begin
               IorD       = 1'b1;
               MemRead    = 1'b1;
               state_next = STATE_W'(S_MEMWB);
            end
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            S_RTYPE_EX: begin
               ALUSrcA = 1'b1;
               Sel     = rtype_sel;
               Illegal = rtype_bad;
               if (!rtype_bad)
                  state_next = STATE_W'(S_RTYPE_WB);
            end
            S_RTYPE_WB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_BEQ: begin
               ALUSrcA = 1'b1;
               Sel     = SEL_SUB;
               PCSrc   = PC_ALUOUT;
               PCEn    = ZF;
            end
            S_ADDI_EX: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = SRCB_IMM;
               Sel        = SEL_ADD;
               state_next = STATE_W'(S_ADDI_WB);
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_JUMP: begin
               PCSrc = PC_JUMP;
               PCEn  = 1'b1;
            end
            default: state_next = STATE_W'(S_FETCH);
         endcase
      end
   end

   assign Estado     = state_reg;
   assign InstrCount = instr_count_reg;

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control: an instruction-level model queues the
// expected per-cycle outputs, and a negedge process checks them every cycle.
module tb_unidad_control;
   import ctrl_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  Opcode, Funct;
   logic        ZF;
   logic        PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [3:0]  Sel;
   logic        Illegal;
   logic [3:0]  Estado;
   logic [31:0] InstrCount;

   unidad_control #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .ZF(ZF),
      .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .Sel(Sel),
      .Illegal(Illegal), .Estado(Estado), .InstrCount(InstrCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic        pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
      logic [1:0]  alusrcb, pcsrc;
      logic [3:0]  sel;
      logic        illegal;
      logic [31:0] cnt;
   } out_t;

   out_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_cnt;

   function automatic logic [4:0] model_alu(input logic [5:0] f);
      // {bad, sel}
      case (f)
         6'b100100: return {1'b0, 4'd0};
         6'b100101: return {1'b0, 4'd1};
         6'b100000: return {1'b0, 4'd2};
         6'b100010: return {1'b0, 4'd6};
         6'b101010: return {1'b0, 4'd7};
         6'b100111: return {1'b0, 4'd12};
         default:   return {1'b1, 4'd2};
      endcase
   endfunction

   task automatic push(input state_t s, input logic [5:0] op, input logic [5:0] f, input logic zf);
      out_t       e;
      logic [4:0] a;
      e     = '0;
      e.st  = s;
      e.cnt = model_cnt;
      a     = model_alu(f);
      case (s)
         S_FETCH:    begin e.memread = 1; e.irwrite = 1; e.alusrcb = 2'b01; e.sel = 4'd2; e.pcen = 1; end
         S_DECODE:   begin e.alusrcb = 2'b11; e.sel = 4'd2; e.illegal = !opcode_known(op); end
         S_MEMADR:   begin e.alusrca = 1; e.alusrcb = 2'b10; e.sel = 4'd2; end
         S_MEMRD:    begin e.iord = 1; e.memread = 1; end
         S_MEMWB:    begin e.memtoreg = 1; e.regwrite = 1; end
         S_MEMWR:    begin e.iord = 1; e.memwrite = 1; end
         S_RTYPE_EX: begin e.alusrca = 1; e.sel = a[3:0]; e.illegal = a[4]; end
         S_RTYPE_WB: begin e.regdst = 1; e.regwrite = 1; end
         S_BEQ:      begin e.alusrca = 1; e.sel = 4'd6; e.pcsrc = 2'b01; e.pcen = zf; end
         S_ADDI_EX:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.sel = 4'd2; end
         S_ADDI_WB:  e.regwrite = 1;
         S_JUMP:     begin e.pcsrc = 2'b10; e.pcen = 1; end
         default:    ;
      endcase
      if (s == S_FETCH) model_cnt = model_cnt + 32'd1;
      exp_q.push_back(e);
   endtask

   // Expected state walk of one instruction, starting at its FETCH cycle.
   task automatic plan_instr(input logic [5:0] op, input logic [5:0] f, input logic zf, output int n);
      logic [4:0] a;
      a = model_alu(f);
      push(S_FETCH, op, f, zf);
      push(S_DECODE, op, f, zf);
      n = 2;
      case (op)
         6'b100011: begin push(S_MEMADR, op, f, zf); push(S_MEMRD, op, f, zf); push(S_MEMWB, op, f, zf); n = 5; end
         6'b101011: begin push(S_MEMADR, op, f, zf); push(S_MEMWR, op, f, zf); n = 4; end
         6'b000000: begin
            push(S_RTYPE_EX, op, f, zf); n = 3;
            if (!a[4]) begin push(S_RTYPE_WB, op, f, zf); n = 4; end
         end
         6'b000100: begin push(S_BEQ, op, f, zf); n = 3; end
         6'b001000: begin push(S_ADDI_EX, op, f, zf); push(S_ADDI_WB, op, f, zf); n = 4; end
         6'b000010: begin push(S_JUMP, op, f, zf); n = 3; end
         default:   ;
      endcase
   endtask

   always @(negedge clk) begin
      out_t e, act;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         act = {Estado, PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, PCSrc, Sel, Illegal, InstrCount};
         vectors++;
         if (act !== e) begin
            miscompares++;
            $display("FAIL cycle_outputs t=%0t state %0d: got %h required %h", $time, e.st, act, e);
         end
         vectors++;
         if (MemRead && MemWrite) begin
            miscompares++;
            $display("FAIL mem_exclusive t=%0t: got MemRead=1 MemWrite=1 required not both", $time);
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   // Runs one instruction; at cycle lit_idx checks hand-computed literal values.
   task automatic run_vec(input string name, input logic [5:0] op, input logic [5:0] f, input logic zf,
                          input int lit_idx, input logic [3:0] l_sel, input logic l_pcen,
                          input logic l_ill, input logic l_rw);
      int n;
      Opcode = op;
      Funct  = f;
      ZF     = zf;
      plan_instr(op, f, zf, n);
      for (int i = 0; i < n; i++) begin
         if (i == lit_idx) begin
            lit({name, "_sel"}, {28'd0, Sel}, {28'd0, l_sel});
            lit({name, "_pcen"}, {31'd0, PCEn}, {31'd0, l_pcen});
            lit({name, "_illegal"}, {31'd0, Illegal}, {31'd0, l_ill});
            lit({name, "_regwrite"}, {31'd0, RegWrite}, {31'd0, l_rw});
         end
         @(posedge clk);
         #1;
      end
      lit({name, "_drained"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int n;
      rst    = 1'b1;
      Opcode = 6'd0;
      Funct  = 6'd0;
      ZF     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      lit("reset_estado", {28'd0, Estado}, 32'd0);
      lit("reset_count", InstrCount, 32'd0);
      lit("reset_illegal", {31'd0, Illegal}, 32'd0);
      lit("reset_fetch_memread", {31'd0, MemRead}, 32'd1);
      rst       = 1'b0;
      model_cnt = 32'd0;

      run_vec("lw",      6'b100011, 6'b000000, 1'b0, 4, 4'd0,  1'b0, 1'b0, 1'b1);
      lit("lw_instrcount", InstrCount, 32'd1);
      run_vec("sw",      6'b101011, 6'b000000, 1'b0, 3, 4'd0,  1'b0, 1'b0, 1'b0);
      run_vec("r_and",   6'b000000, 6'b100100, 1'b0, 2, 4'd0,  1'b0, 1'b0, 1'b0);
      run_vec("r_or",    6'b000000, 6'b100101, 1'b0, 2, 4'd1,  1'b0, 1'b0, 1'b0);
      run_vec("r_add",   6'b000000, 6'b100000, 1'b0, 2, 4'd2,  1'b0, 1'b0, 1'b0);
      run_vec("r_sub",   6'b000000, 6'b100010, 1'b0, 2, 4'd6,  1'b0, 1'b0, 1'b0);
      run_vec("r_slt",   6'b000000, 6'b101010, 1'b0, 2, 4'd7,  1'b0, 1'b0, 1'b0);
      run_vec("r_nor",   6'b000000, 6'b100111, 1'b0, 2, 4'd12, 1'b0, 1'b0, 1'b0);
      run_vec("r_bad",   6'b000000, 6'b000011, 1'b0, 2, 4'd2,  1'b0, 1'b1, 1'b0);
      run_vec("beq_z1",  6'b000100, 6'b000000, 1'b1, 2, 4'd6,  1'b1, 1'b0, 1'b0);
      run_vec("beq_z0",  6'b000100, 6'b000000, 1'b0, 2, 4'd6,  1'b0, 1'b0, 1'b0);
      run_vec("addi",    6'b001000, 6'b000000, 1'b0, 3, 4'd0,  1'b0, 1'b0, 1'b1);
      run_vec("jump",    6'b000010, 6'b000000, 1'b0, 2, 4'd0,  1'b1, 1'b0, 1'b0);
      run_vec("bad_op",  6'b111111, 6'b000000, 1'b0, 1, 4'd2,  1'b0, 1'b1, 1'b0);
      lit("bad_op_back_to_fetch", {28'd0, Estado}, 32'd0);
      lit("instrcount_after_14", InstrCount, 32'd14);

      // Reset in the MEMWR cycle of a store abandons it.
      Opcode = 6'b101011;
      Funct  = 6'd0;
      plan_instr(Opcode, Funct, 1'b0, n);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
      end
      lit("memwr_reached", {31'd0, MemWrite}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      model_cnt = 32'd0;
      lit("rst_memwr_memwrite", {31'd0, MemWrite}, 32'd0);
      lit("rst_memwr_estado", {28'd0, Estado}, 32'd0);
      lit("rst_memwr_count", InstrCount, 32'd0);
      lit("rst_memwr_illegal", {31'd0, Illegal}, 32'd0);
      lit("rst_memwr_drained", exp_q.size(), 32'd0);

      // Counter wrap: preload all-ones during a FETCH cycle.
      force dut.instr_count_reg = 32'hFFFFFFFF;
      #1;
      release dut.instr_count_reg;
      model_cnt = 32'hFFFFFFFF;
      run_vec("wrap_j",  6'b000010, 6'b000000, 1'b0, 1, 4'd2,  1'b0, 1'b0, 1'b0);
      lit("wrap_count", InstrCount, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
